// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide execution unit:
// M-extension func3/func7 encodings and the sequencer state encoding.
package ex_muldiv_pkg;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [6:0] INST_FUNC7_M = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step. The caller supplies the partial remainder
// already shifted left with the next dividend bit appended (XLEN+1 bits);
// the step subtracts the divisor when it fits and reports the quotient bit.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   i_prem,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_prem,
  output logic            o_qbit
);

  logic [XLEN:0] w_diff;

  // Trial subtraction: a clear top bit means the divisor fits.
  always_comb begin
    w_diff = i_prem - {1'b0, i_divisor};
    o_qbit = ~w_diff[XLEN];
    o_prem = o_qbit ? w_diff[XLEN-1:0] : i_prem[XLEN-1:0];
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Operands are reduced to magnitudes on accept, iterated one bit per cycle
// in CALC, and the sign-fixed result is written back in DONE.
// Build option: MULDIV_FAST_MUL_EN makes every multiply a single-cycle fast
// path; otherwise multiply shares the iterative shift-add datapath.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            hold_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o
);

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_w(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  md_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_func3;
  logic [4:0]        r_rd_addr;
  logic              r_res_neg, r_rem_neg;
  logic [XLEN-1:0]   r_rem, r_dvd, r_op2, r_rd_data;

  logic              w_accept, w_s1, w_s2, w_neg1, w_neg2;
  logic              w_div_zero, w_ovf, w_res_neg, w_fast;
  logic [XLEN-1:0]   w_abs1, w_abs2, w_fast_data;
  logic [XLEN-1:0]   w_step_rem, w_quot_nxt, w_rem_nxt, w_dvd_nxt, w_calc_res;
  logic              w_qbit;

  // Operand signedness and magnitudes. MUL low half is sign-agnostic, so it
  // is handled as signed x signed like MULH.
  always_comb begin
    w_accept   = (r_state == MD_IDLE) & valid_i & ~flush_i;
    w_s1       = func3_i[2] ? ~func3_i[0] : (func3_i[1:0] != 2'b11);
    w_s2       = func3_i[2] ? ~func3_i[0] : ~func3_i[1];
    w_neg1     = w_s1 & op1_i[XLEN-1];
    w_neg2     = w_s2 & op2_i[XLEN-1];
    w_abs1     = neg_if(op1_i, w_neg1);
    w_abs2     = neg_if(op2_i, w_neg2);
    w_div_zero = func3_i[2] & (op2_i == '0);
    w_ovf      = func3_i[2] & ~func3_i[0] & (op1_i == SMIN) & (op2_i == '1);
    w_res_neg  = (w_neg1 ^ w_neg2) & ~w_div_zero;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     w_mul_a, w_mul_b;
  logic        [2*XLEN-1:0] w_mul_prod;

  // Single wide product on sign-extended operands; only the low 2*XLEN bits matter.
  always_comb begin
    w_mul_a    = $signed({w_s1 & op1_i[XLEN-1], op1_i});
    w_mul_b    = $signed({w_s2 & op2_i[XLEN-1], op2_i});
    w_mul_prod = (2*XLEN)'(w_mul_a) * (2*XLEN)'(w_mul_b);
  end
`endif

  // Requests that resolve without iterating: divide by zero, signed overflow
  // and, when enabled, every multiply.
  always_comb begin
    w_fast      = 1'b0;
    w_fast_data = '0;
    if (w_div_zero) begin
      w_fast      = 1'b1;
      w_fast_data = func3_i[1] ? op1_i : '1;
    end else if (w_ovf) begin
      w_fast      = 1'b1;
      w_fast_data = func3_i[1] ? '0 : SMIN;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (~func3_i[2]) begin
      w_fast      = 1'b1;
      w_fast_data = (func3_i[1:0] == INST_MUL[1:0]) ? w_mul_prod[XLEN-1:0]
                                                     : w_mul_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .i_prem    ({r_rem, r_dvd[XLEN-1]}),
    .i_divisor (r_op2),
    .o_prem    (w_step_rem),
    .o_qbit    (w_qbit)
  );

`ifdef MULDIV_FAST_MUL_EN
  // CALC iteration: divide only; result sign-fixed from the final step.
  always_comb begin
    w_quot_nxt = {r_dvd[XLEN-2:0], w_qbit};
    w_rem_nxt  = w_step_rem;
    w_dvd_nxt  = w_quot_nxt;
    w_calc_res = r_func3[1] ? neg_if(w_step_rem, r_rem_neg) : neg_if(w_quot_nxt, r_res_neg);
  end
`else
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_prod_nxt, w_prod_fix;

  // CALC iteration: restoring divide or shift-add multiply on shared registers.
  // For multiply r_rem is the accumulator high half and r_dvd the low half,
  // which starts out holding the multiplier.
  always_comb begin
    w_quot_nxt = {r_dvd[XLEN-2:0], w_qbit};
    w_sum      = {1'b0, r_rem} + (r_dvd[0] ? {1'b0, r_op2} : '0);
    w_prod_nxt = {w_sum, r_dvd[XLEN-1:1]};
    w_prod_fix = neg_if_w(w_prod_nxt, r_res_neg);
    if (r_func3[2]) begin
      w_rem_nxt  = w_step_rem;
      w_dvd_nxt  = w_quot_nxt;
      w_calc_res = r_func3[1] ? neg_if(w_step_rem, r_rem_neg) : neg_if(w_quot_nxt, r_res_neg);
    end else begin
      w_rem_nxt  = w_sum[XLEN:1];
      w_dvd_nxt  = {w_sum[0], r_dvd[XLEN-1:1]};
      w_calc_res = (r_func3[1:0] == INST_MUL[1:0]) ? w_prod_fix[XLEN-1:0]
                                                    : w_prod_fix[2*XLEN-1:XLEN];
    end
  end
`endif

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and stall request; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    hold_o      = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (valid_i && !flush_i) begin
          hold_o      = 1'b1;
          w_state_nxt = w_fast ? MD_DONE : MD_CALC;
        end
      end
      MD_CALC: begin
        hold_o = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = MD_DONE;
      end
      MD_DONE: w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
    if (flush_i) w_state_nxt = MD_IDLE;
  end

  // Datapath: latch magnitudes on accept, iterate in CALC, capture the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_func3   <= '0;
      r_rd_addr <= '0;
      r_res_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_op2     <= '0;
      r_rd_data <= '0;
    end else if (w_accept) begin
      r_cnt     <= w_fast ? '0 : CNT_W'(XLEN);
      r_func3   <= func3_i;
      r_rd_addr <= rd_addr_i;
      r_res_neg <= w_res_neg;
      r_rem_neg <= w_neg1;
      r_rem     <= '0;
      r_dvd     <= w_abs1;
      r_op2     <= w_abs2;
      r_rd_data <= w_fast_data;
    end else if (r_state == MD_CALC) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_rem <= w_rem_nxt;
      r_dvd <= w_dvd_nxt;
      if (r_cnt == CNT_W'(1)) r_rd_data <= w_calc_res;
    end
  end

  // Write-back port is quiet outside DONE; a flush in DONE cancels the write.
  always_comb begin
    rd_wen_o  = (r_state == MD_DONE) & ~flush_i;
    rd_data_o = (r_state == MD_DONE) ? r_rd_data : '0;
    rd_addr_o = (r_state == MD_DONE) ? r_rd_addr : '0;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv (XLEN=32).
module tb_ex_muldiv;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_i = 1'b0;
  logic [2:0]      func3_i = '0;
  logic [XLEN-1:0] op1_i = '0;
  logic [XLEN-1:0] op2_i = '0;
  logic [4:0]      rd_addr_i = '0;
  logic            flush_i = 1'b0;
  logic            hold_o;
  logic [XLEN-1:0] rd_data_o;
  logic [4:0]      rd_addr_o;
  logic            rd_wen_o;

  int checks = 0;
  int errors = 0;

  ex_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .func3_i   (func3_i),
    .op1_i     (op1_i),
    .op2_i     (op2_i),
    .rd_addr_i (rd_addr_i),
    .flush_i   (flush_i),
    .hold_o    (hold_o),
    .rd_data_o (rd_data_o),
    .rd_addr_o (rd_addr_o),
    .rd_wen_o  (rd_wen_o)
  );

  always #5 clk = ~clk;

  // Present one request and observe it: cycle index of the first write-back
  // relative to the accept cycle, its data/address, hold cycles and pulses.
  task automatic do_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [4:0] rd, input bit skip_edge,
                       output int lat, output logic [XLEN-1:0] data, output logic [4:0] addr,
                       output int holds, output int wens);
    lat = -1; data = '0; addr = '0; holds = 0; wens = 0;
    if (!skip_edge) begin
      @(posedge clk); #1;
    end
    valid_i = 1'b1; func3_i = f3; op1_i = a; op2_i = b; rd_addr_i = rd;
    for (int k = 0; k < XLEN + 8; k++) begin
      @(negedge clk);
      if (hold_o) holds++;
      if (rd_wen_o) begin
        wens++;
        if (lat < 0) begin
          lat = k; data = rd_data_o; addr = rd_addr_o;
        end
      end
      if (lat >= 0 && k > lat) break;
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset;
    #22;
    checks++;
    if (hold_o !== 1'b0 || rd_wen_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got hold=%b wen=%b, expected 0 0", hold_o, rd_wen_o);
    end
    checks++;
    if (rd_data_o !== '0 || rd_addr_o !== '0) begin
      errors++; $display("FAIL reset_data: got data=%h addr=%h, expected 0 0", rd_data_o, rd_addr_o);
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_divide;
    logic [2:0]      f3s  [8] = '{F_DIV, F_REM, F_DIV, F_REM, F_DIVU, F_REMU, F_DIV, F_REM};
    logic [XLEN-1:0] as   [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                  32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
    logic [XLEN-1:0] bs   [8] = '{32'h2, 32'h2, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [XLEN-1:0] exps [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF2, 32'h2,
                                  32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    int              lats [8] = '{DIV_LAT, DIV_LAT, DIV_LAT, DIV_LAT, 1, 1, 1, 1};
    int lat, holds, wens;
    logic [XLEN-1:0] data;
    logic [4:0] addr;
    for (int i = 0; i < 8; i++) begin
      do_op(f3s[i], as[i], bs[i], 5'(i + 1), 1'b0, lat, data, addr, holds, wens);
      checks++;
      if (data !== exps[i]) begin
        errors++; $display("FAIL div%0d data: got %h expected %h", i, data, exps[i]);
      end
      checks++;
      if (lat != lats[i] || holds != lats[i] || wens != 1) begin
        errors++; $display("FAIL div%0d timing: got lat=%0d hold=%0d pulses=%0d expected %0d %0d 1",
                           i, lat, holds, wens, lats[i], lats[i]);
      end
      checks++;
      if (addr !== 5'(i + 1)) begin
        errors++; $display("FAIL div%0d addr: got %0d expected %0d", i, addr, i + 1);
      end
    end
  endtask

  task automatic test_multiply;
    logic [2:0]      f3s  [5] = '{F_MUL, F_MULH, F_MULHSU, F_MULHU, F_MUL};
    logic [XLEN-1:0] as   [5] = '{32'h3, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
    logic [XLEN-1:0] bs   [5] = '{32'hFFFFFFFB, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h10};
    logic [XLEN-1:0] exps [5] = '{32'hFFFFFFF1, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h23456780};
    int lat, holds, wens;
    logic [XLEN-1:0] data;
    logic [4:0] addr;
    for (int i = 0; i < 5; i++) begin
      do_op(f3s[i], as[i], bs[i], 5'(20 + i), 1'b0, lat, data, addr, holds, wens);
      checks++;
      if (data !== exps[i]) begin
        errors++; $display("FAIL mul%0d data: got %h expected %h", i, data, exps[i]);
      end
      checks++;
      if (lat != MUL_LAT || holds != MUL_LAT || wens != 1 || addr !== 5'(20 + i)) begin
        errors++; $display("FAIL mul%0d timing: got lat=%0d hold=%0d pulses=%0d addr=%0d expected %0d %0d 1 %0d",
                           i, lat, holds, wens, addr, MUL_LAT, MUL_LAT, 20 + i);
      end
    end
  endtask

  task automatic test_flush;
    int bad, lat, holds, wens;
    logic [XLEN-1:0] data;
    logic [4:0] addr;
    bad = 0;
    @(posedge clk); #1;
    valid_i = 1'b1; func3_i = F_DIVU; op1_i = 32'hFFFF0000; op2_i = 32'h3; rd_addr_i = 5'd9;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_wen_o) bad++;
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
    flush_i = 1'b1;
    #1;
    if (rd_wen_o) bad++;
    checks++;
    if (hold_o !== 1'b1) begin
      errors++; $display("FAIL flush_hold_calc: got %b expected 1", hold_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    if (rd_wen_o) bad++;
    checks++;
    if (hold_o !== 1'b0) begin
      errors++; $display("FAIL flush_hold_after: got %b expected 0", hold_o);
    end
    do_op(F_DIVU, 32'd100, 32'd7, 5'd3, 1'b1, lat, data, addr, holds, wens);
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL flush_no_write: got %0d pulses expected 0", bad);
    end
    checks++;
    if (data !== 32'd14 || addr !== 5'd3) begin
      errors++; $display("FAIL flush_next_data: got %h/%0d expected 0000000e/3", data, addr);
    end
    checks++;
    if (lat != DIV_LAT || wens != 1) begin
      errors++; $display("FAIL flush_next_lat: got %0d/%0d expected %0d/1", lat, wens, DIV_LAT);
    end
  endtask

  task automatic test_reset_mid;
    int lat, holds, wens;
    logic [XLEN-1:0] data;
    logic [4:0] addr;
    @(posedge clk); #1;
    valid_i = 1'b1; func3_i = F_DIV; op1_i = 32'd1000; op2_i = 32'hFFFFFFFD; rd_addr_i = 5'd5;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (hold_o !== 1'b0 || rd_wen_o !== 1'b0 || rd_data_o !== '0 || rd_addr_o !== '0) begin
      errors++; $display("FAIL midreset_outputs: got hold=%b wen=%b data=%h addr=%0d expected all 0",
                         hold_o, rd_wen_o, rd_data_o, rd_addr_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(F_REMU, 32'd10, 32'd3, 5'd7, 1'b0, lat, data, addr, holds, wens);
    checks++;
    if (data !== 32'd1 || addr !== 5'd7) begin
      errors++; $display("FAIL midreset_remu: got %h/%0d expected 00000001/7", data, addr);
    end
    checks++;
    if (lat != DIV_LAT || holds != DIV_LAT || wens != 1) begin
      errors++; $display("FAIL midreset_lat: got lat=%0d hold=%0d pulses=%0d expected %0d %0d 1",
                         lat, holds, wens, DIV_LAT, DIV_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_multiply();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
